// File: rtl/operand_fetch.sv
// operand_fetch: register-file operand fetch stage (IDLE -> READ -> VALID), rev 1.0
// Optional writeback forwarding into the read cycle: define OPERAND_FETCH_BYPASS_EN.
`default_nettype none

module operand_fetch (
   input  logic        CLK,
   input  logic        ResetN,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] InInstr,
   input  logic [31:0] InPC,
   output logic [4:0]  ReadAddress1,
   output logic [4:0]  ReadAddress2,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   input  logic        WbEn,
   input  logic [4:0]  WbAddress,
   input  logic [31:0] WbData,
   input  logic        Flush,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutInstr,
   output logic [31:0] OutPC,
   output logic [31:0] OutOp1,
   output logic [31:0] OutOp2
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state;
   logic        started;
   logic        accept;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] op1_next;
   logic [31:0] op2_next;

   assign rs1 = OutInstr[19:15];
   assign rs2 = OutInstr[24:20];

   // Addresses sit at zero outside READ so each read starts with an address change.
   assign ReadAddress1 = (state == READ) ? rs1 : 5'd0;
   assign ReadAddress2 = (state == READ) ? rs2 : 5'd0;

   assign OutValid = (state == VALID);
   assign InReady  = started & ~Flush &
                     ((state == IDLE) | ((state == VALID) & OutReady));
   assign accept   = InValid & InReady;

   always_comb begin
      op1_next = ReadData1;
      op2_next = ReadData2;
`ifdef OPERAND_FETCH_BYPASS_EN
      if (WbEn && (WbAddress == rs1)) op1_next = WbData;
      if (WbEn && (WbAddress == rs2)) op2_next = WbData;
`endif
      if (rs1 == 5'd0) op1_next = 32'h0;
      if (rs2 == 5'd0) op2_next = 32'h0;
   end

`ifndef OPERAND_FETCH_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{WbEn, WbAddress, WbData};
`endif

   // started keeps InReady low until the first edge after reset release.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state    <= IDLE;
         started  <= 1'b0;
         OutInstr <= 32'h0;
         OutPC    <= 32'h0;
         OutOp1   <= 32'h0;
         OutOp2   <= 32'h0;
      end else begin
         started <= 1'b1;
         if (Flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     OutInstr <= InInstr;
                     OutPC    <= InPC;
                     state    <= READ;
                  end
               end
               READ: begin
                  OutOp1 <= op1_next;
                  OutOp2 <= op2_next;
                  state  <= VALID;
               end
               VALID: begin
                  if (OutReady) begin
                     if (accept) begin
                        OutInstr <= InInstr;
                        OutPC    <= InPC;
                        state    <= READ;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against a transaction-level model.
`default_nettype none

module tb_operand_fetch;

   logic        CLK = 1'b0;
   logic        ResetN = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [31:0] InInstr = 32'h0;
   logic [31:0] InPC = 32'h0;
   logic [4:0]  ReadAddress1;
   logic [4:0]  ReadAddress2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        WbEn = 1'b0;
   logic [4:0]  WbAddress = 5'd0;
   logic [31:0] WbData = 32'h0;
   logic        Flush = 1'b0;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic [31:0] OutInstr;
   logic [31:0] OutPC;
   logic [31:0] OutOp1;
   logic [31:0] OutOp2;

`ifdef OPERAND_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   operand_fetch dut (
      .CLK(CLK), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
      .InInstr(InInstr), .InPC(InPC), .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .WbEn(WbEn), .WbAddress(WbAddress),
      .WbData(WbData), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
      .OutInstr(OutInstr), .OutPC(OutPC), .OutOp1(OutOp1), .OutOp2(OutOp2)
   );

   always #5 CLK = ~CLK;

   // Register file: asynchronous read, write at the clock edge, x0 hardwired.
   logic [31:0] regs [32];
   assign ReadData1 = regs[ReadAddress1];
   assign ReadData2 = regs[ReadAddress2];

   int total = 0;
   int bad = 0;

   // Model: at most one instruction in flight; age 0 = reading, age 1 = presented.
   bit          m_held, m_age, m_started;
   logic [31:0] m_instr, m_pc, m_op1, m_op2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      return {7'h0, r2, r1, 3'h0, rd, 7'h33};
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] rs);
      if (rs == 5'd0) return 32'h0;
      if (BYP && WbEn && WbAddress == rs) return WbData;
      return regs[rs];
   endfunction

   task automatic model_reset();
      m_held = 0; m_age = 0; m_started = 0;
      m_instr = 32'h0; m_pc = 32'h0; m_op1 = 32'h0; m_op2 = 32'h0;
   endtask

   function automatic bit exp_ready();
      return ResetN && m_started && !Flush && (!m_held || (m_age && OutReady));
   endfunction

   task automatic compare();
      chk("in_ready", {31'h0, InReady}, {31'h0, exp_ready()});
      chk("out_valid", {31'h0, OutValid}, {31'h0, m_held && m_age});
      chk("raddr1", {27'h0, ReadAddress1}, (m_held && !m_age) ? {27'h0, m_instr[19:15]} : 32'h0);
      chk("raddr2", {27'h0, ReadAddress2}, (m_held && !m_age) ? {27'h0, m_instr[24:20]} : 32'h0);
      if (m_held && m_age) begin
         chk("out_instr", OutInstr, m_instr);
         chk("out_pc", OutPC, m_pc);
         chk("out_op1", OutOp1, m_op1);
         chk("out_op2", OutOp2, m_op2);
      end
   endtask

   task automatic model_edge();
      bit acc;
      if (!ResetN) begin
         model_reset();
         return;
      end
      acc = exp_ready() && InValid;
      if (Flush) begin
         m_held = 0;
      end else if (m_held && !m_age) begin
         m_op1 = operand(m_instr[19:15]);
         m_op2 = operand(m_instr[24:20]);
         m_age = 1;
      end else if (acc) begin
         m_held = 1; m_age = 0; m_instr = InInstr; m_pc = InPC;
      end else if (m_held && m_age && OutReady) begin
         m_held = 0;
      end
      m_started = 1;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      if (!ResetN) model_reset();
      #1 compare();
      @(posedge CLK);
      model_edge();
      if (ResetN && WbEn && WbAddress != 5'd0) regs[WbAddress] <= WbData;
      @(negedge CLK);
   endtask

   task automatic drv(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit we,
                      input logic [4:0] wa, input logic [31:0] wd);
      InValid = iv; InInstr = ins; InPC = pc; OutReady = ordy; Flush = fl;
      WbEn = we; WbAddress = wa; WbData = wd;
   endtask

   task automatic idle(input bit ordy);
      drv(0, 32'h0, 32'h0, ordy, 0, 0, 5'd0, 32'h0);
   endtask

   logic [31:0] held_op1;

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
      regs[3] = 32'h1234;
      regs[5] = 32'h0BAD_F00D;
      regs[7] = 32'h0000_0700;
      model_reset();
      @(negedge CLK);
      idle(0);
      step(); step();

      // Release reset: ready only after the first edge, then accept rs1=3, rs2=0.
      ResetN = 1;
      drv(1, mk(5'd3, 5'd0, 5'd1), 32'h100, 0, 0, 0, 5'd0, 32'h0);
      #1 chk("ready_low_after_release", {31'h0, InReady}, 32'h0);
      step();
      #1 chk("ready_high_second_cycle", {31'h0, InReady}, 32'h1);
      step();
      idle(0);
      #1 chk("read_phase_not_valid", {31'h0, OutValid}, 32'h0);
      chk("read_phase_addr1", {27'h0, ReadAddress1}, 32'd3);
      step();
      #1 chk("x3_op1", OutOp1, 32'h1234);
      chk("x3_op2_zero", OutOp2, 32'h0);
      chk("x3_valid", {31'h0, OutValid}, 32'h1);

      // Both operands x5 with a same-cycle writeback to x5 during READ.
      drv(1, mk(5'd5, 5'd5, 5'd2), 32'h104, 1, 0, 0, 5'd0, 32'h0);
      step();
      drv(0, 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
      step();
      idle(0);
      #1 chk("x5_bypass_op1", OutOp1, BYP ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
      chk("x5_bypass_op2", OutOp2, BYP ? 32'hDEAD_BEEF : 32'h0BAD_F00D);

      // Stall four cycles with a waiting instruction, then release.
      held_op1 = OutOp1;
      for (int i = 0; i < 4; i++) begin
         drv(1, mk(5'd3, 5'd5, 5'd3), 32'h108, 0, 0, 0, 5'd0, 32'h0);
         #1 chk("stall_ready_low", {31'h0, InReady}, 32'h0);
         chk("stall_op1_stable", OutOp1, held_op1);
         step();
      end
      OutReady = 1;
      #1 chk("release_ready", {31'h0, InReady}, 32'h1);
      step();
      idle(0);
      step();
      #1 chk("after_stall_valid", {31'h0, OutValid}, 32'h1);
      chk("after_stall_op1", OutOp1, 32'h1234);
      chk("after_stall_op2", OutOp2, 32'hDEAD_BEEF);

      // Back-to-back reads of x7 with a write to x7 between them.
      drv(1, mk(5'd7, 5'd0, 5'd4), 32'h10C, 1, 0, 0, 5'd0, 32'h0);
      step();
      idle(0);
      step();
      drv(1, mk(5'd7, 5'd0, 5'd5), 32'h110, 1, 0, 1, 5'd7, 32'h7777_6666);
      #1 chk("x7_first_op1", OutOp1, 32'h0000_0700);
      chk("x7_addr_back_to_zero", {27'h0, ReadAddress1}, 32'h0);
      step();
      idle(0);
      step();
      #1 chk("x7_second_op1", OutOp1, 32'h7777_6666);

      // Flush during READ, then flush during VALID with a waiting instruction.
      drv(1, mk(5'd1, 5'd2, 5'd6), 32'h114, 1, 0, 0, 5'd0, 32'h0);
      step();
      drv(1, mk(5'd1, 5'd2, 5'd6), 32'h118, 1, 1, 0, 5'd0, 32'h0);
      #1 chk("flush_read_ready", {31'h0, InReady}, 32'h0);
      step();
      idle(0);
      #1 chk("flush_read_valid", {31'h0, OutValid}, 32'h0);
      drv(1, mk(5'd4, 5'd6, 5'd6), 32'h11C, 0, 0, 0, 5'd0, 32'h0);
      step();
      idle(0);
      step();
      drv(1, mk(5'd2, 5'd2, 5'd6), 32'h120, 1, 1, 0, 5'd0, 32'h0);
      #1 chk("flush_valid_ready", {31'h0, InReady}, 32'h0);
      step();
      idle(0);
      #1 chk("flush_valid_out", {31'h0, OutValid}, 32'h0);
      chk("flush_valid_addr", {27'h0, ReadAddress1}, 32'h0);

      // Reset while presenting nonzero outputs.
      drv(1, mk(5'd3, 5'd7, 5'd1), 32'hABC0, 0, 0, 0, 5'd0, 32'h0);
      step();
      drv(1, mk(5'd3, 5'd7, 5'd1), 32'hABC4, 0, 0, 0, 5'd0, 32'h0);
      step();
      ResetN = 0;
      #1 chk("rst_valid", {31'h0, OutValid}, 32'h0);
      chk("rst_op1", OutOp1, 32'h0);
      chk("rst_op2", OutOp2, 32'h0);
      chk("rst_instr", OutInstr, 32'h0);
      chk("rst_pc", OutPC, 32'h0);
      chk("rst_ready", {31'h0, InReady}, 32'h0);
      chk("rst_addr", {27'h0, ReadAddress1, ReadAddress2}, 32'h0);
      step(); step();
      ResetN = 1;
      step();
      step();
      idle(1);
      step();
      #1 chk("post_rst_valid", {31'h0, OutValid}, 32'h1);
      chk("post_rst_pc", OutPC, 32'hABC4);

      // Randomized traffic, including rare flushes and asynchronous resets.
      for (int n = 0; n < 4000; n++) begin
         ResetN    = ($urandom_range(0, 299) != 0);
         InValid   = ($urandom_range(0, 9) < 7);
         InInstr   = ($urandom & 32'hFE07_7FFF) |
                     {7'h0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 15'h0};
         InPC      = $urandom;
         OutReady  = ($urandom_range(0, 9) < 6);
         Flush     = ($urandom_range(0, 19) == 0);
         WbEn      = $urandom_range(0, 1);
         WbAddress = 5'($urandom_range(0, 7));
         WbData    = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
